uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Byte-serial UART transmitter: the emitting end of the console path that prints text such as "Hello World!" from the core to a host terminal or simulation bench.
- Accepts bytes from the core over a valid/ready handshake and serialises each one as an 8N1 frame, with optional parity and a second stop bit.
- Sits between the core's console/MMIO write port and the board TX pin.
- Clocked at the 100 MHz (10 ns) system clock.

Parameters:
- CLK_DIV, 868, clock cycles per bit (100 MHz / 115200 baud); legal range 2..65535.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, with PARITY_EN=1: 0 = even parity, 1 = odd parity.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-high.
- tx_data  input  8  byte to send; sampled on handshake.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  transmitter can accept a byte this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress (start bit through last stop bit).

Behaviour:
- One clock. Reset is synchronous and active-high: the clk and rst ports; rst is sampled only on posedge clk.
- Reset values:
  - tx=1, busy=0, tx_ready=1.
  - State IDLE; bit counter and divider counter 0; shift register 0.
- Reset mid-frame: the frame is aborted. tx is 1 on the cycle after the rst edge, and no further frame bits are emitted.
- Handshake:
  - A byte is accepted on a posedge where tx_valid && tx_ready.
  - tx_data is latched into the shift register; parity is computed from the latched byte.
  - tx_valid without tx_ready is held off with no effect. The source keeps tx_data stable until acceptance.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
  - IDLE: tx=1, tx_ready=1, busy=0. On acceptance -> START.
  - START: tx=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, each CLK_DIV cycles; a 3-bit counter indexes the bit.
  - PARITY (only when PARITY_EN=1): tx = ^data XOR PARITY_ODD, for CLK_DIV cycles.
  - STOP: tx=1 for STOP_BITS*CLK_DIV cycles.
- Latency: tx falls on the first posedge after the accepting edge, so the start bit is registered out one cycle after acceptance.
- Bit timing:
  - A divider counts 0..CLK_DIV-1 and reloads 0 at the end of each bit.
  - Bit period is exactly CLK_DIV cycles; no drift across frames.
- Frame length: (10 + PARITY_EN + STOP_BITS - 1) * CLK_DIV cycles.
- Early ready:
  - tx_ready is also 1 during the final cycle of the last stop bit.
  - Acceptance in that cycle moves STOP -> START directly, so back-to-back frames have zero idle gap.
  - Otherwise STOP -> IDLE.
- busy = (state != IDLE). It stays 1 across back-to-back frames.
- tx is driven from a flop (glitch-free). tx_ready is combinational from state and counters.
- Reset priority: rst asserted together with tx_valid means rst wins; the byte is not accepted.

Decomposition:
- Package uart_pkg holds:
  - State enum type uart_state_t (IDLE, START, DATA, PARITY, STOP).
  - Constant UART_DATA_BITS = 8.
  - Default UART_CLK_DIV = 868.
- One sub-module, uart_baud_cnt:
  - Divider counter with a clear input.
  - bit_end pulse on the cycle count == CLK_DIV-1.
  - Shared later by uart_rx.
- The FSM and shift register stay in uart_tx.

Test Plan (CLK_DIV=4 unless stated):
- Reset and idle: rst=1 for 10 cycles, then release -> tx=1, busy=0, tx_ready=1 throughout; no transitions for 20 cycles.
- Single byte: send 0x48 ('H') -> tx low one cycle after acceptance, then 0,0,0,1,0,0,1,0 (LSB first), then 1. Each bit is exactly 4 cycles; busy high for 40 cycles.
- Back-to-back "Hello World!": tx_valid held high with all 12 bytes queued -> 12 contiguous 40-cycle frames with no gap. A bench-side UART decoder reproduces the string; tx_ready is high only on each frame's last cycle.
- Parity: PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1, frame 44 cycles. With PARITY_ODD=1 -> parity bit 0. STOP_BITS=2 -> frame 48 cycles.
- Backpressure: tx_valid asserted mid-frame with 0x55, then data changed to 0xAA before ready -> only the byte present at the ready edge is sent. Earlier values are never latched.
- Reset mid-frame: assert rst during DATA bit 3 of 0x00 -> tx=1, busy=0 on the next cycle. The next byte 0x41 is sent as a clean, correctly timed frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_CLK_DIV   = 868;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period divider: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] count;

  assign bit_end = (count == CW'(CLK_DIV - 1));

  // Free-running divider held at zero while cleared, wrapping at the end of every bit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (bit_end) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Byte-serial UART transmitter: valid/ready byte input, 8 data bits LSB first,
// optional parity, one or two stop bits. tx lags the state register by one cycle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = UART_CLK_DIV,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  uart_state_t state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        parity_bit;
  logic        bit_end;
  logic        last_stop;
  logic        accept;
  logic        div_clear;

  // The final cycle of the last stop bit can already take the next byte.
  assign last_stop = (state == STOP) && bit_end && (bit_cnt == 3'(STOP_BITS - 1));
  assign tx_ready  = (state == IDLE) || last_stop;
  assign accept    = tx_valid && tx_ready;
  assign busy      = (state != IDLE);
  assign div_clear = (state == IDLE);

  uart_baud_cnt #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (div_clear),
    .bit_end(bit_end)
  );

  // Frame sequencer, shift register and registered serial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_reg[0];
        PARITY:  tx <= parity_bit;
        default: tx <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          if (accept) begin
            state      <= START;
            shift_reg  <= tx_data;
            parity_bit <= (^tx_data) ^ PARITY_ODD;
            bit_cnt    <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
              state <= PARITY_EN ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            bit_cnt <= '0;
          end
        end
        STOP: begin
          if (last_stop) begin
            bit_cnt <= '0;
            if (accept) begin
              state      <= START;
              shift_reg  <= tx_data;
              parity_bit <= (^tx_data) ^ PARITY_ODD;
            end else begin
              state <= IDLE;
            end
          end else if (bit_end) begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four instances (8N1, even parity, odd parity,
// even parity with two stop bits) share clock and reset; a per-line decoder
// pops expected bytes and checks data, parity, bit timing and the ready window.
module tb_uart_tx;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data  [4];
  logic       tx_valid [4];
  logic       tx_ready [4];
  logic       tx_line  [4];
  logic       busy     [4];

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  logic [8:0] exp_q2[$];
  logic [8:0] exp_q3[$];

  bit         mon_act      [4];
  int         mon_cnt      [4];
  logic [11:0] mon_bits    [4];
  logic [7:0] mon_exp      [4];
  logic       mon_par      [4];
  logic [7:0] mon_dec      [4];
  logic       mon_dec_par  [4];
  bit         mon_shape_ok [4];
  bit         mon_ready_ok [4];

  initial forever #5 clk = ~clk;

  uart_tx #(.CLK_DIV(DIV), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx(tx_line[0]), .busy(busy[0]));

  uart_tx #(.CLK_DIV(DIV), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx(tx_line[1]), .busy(busy[1]));

  uart_tx #(.CLK_DIV(DIV), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx(tx_line[2]), .busy(busy[2]));

  uart_tx #(.CLK_DIV(DIV), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst(rst), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .tx(tx_line[3]), .busy(busy[3]));

  // Frame length in clock cycles for each instance's configuration.
  function automatic int frame_len(int i);
    case (i)
      0:       return 40;
      1:       return 44;
      2:       return 44;
      default: return 48;
    endcase
  endfunction

  function automatic bit has_parity(int i);
    return (i != 0);
  endfunction

  task automatic push_exp(int i, logic [7:0] d, logic p);
    case (i)
      0:       exp_q0.push_back({p, d});
      1:       exp_q1.push_back({p, d});
      2:       exp_q2.push_back({p, d});
      default: exp_q3.push_back({p, d});
    endcase
  endtask

  // Returns {found, parity, data}.
  function automatic logic [9:0] pop_exp(int i);
    logic [9:0] r;
    r = '0;
    case (i)
      0:       if (exp_q0.size() > 0) r = {1'b1, exp_q0.pop_front()};
      1:       if (exp_q1.size() > 0) r = {1'b1, exp_q1.pop_front()};
      2:       if (exp_q2.size() > 0) r = {1'b1, exp_q2.pop_front()};
      default: if (exp_q3.size() > 0) r = {1'b1, exp_q3.pop_front()};
    endcase
    return r;
  endfunction

  function automatic int pending();
    return exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size();
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present a byte and hold it until the DUT accepts it; the expected byte is
  // queued on the accepting edge. Caller is in the posedge+1 phase.
  task automatic applyStimulus(int i, logic [7:0] d, logic p);
    int n;
    n = 0;
    tx_data[i]  = d;
    tx_valid[i] = 1'b1;
    while (!tx_ready[i] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!tx_ready[i]) begin
      checkOutput($sformatf("accept_timeout[%0d]", i), tx_ready[i], 1);
      tx_valid[i] = 1'b0;
    end else begin
      @(posedge clk);
      push_exp(i, d, p);
      #1;
    end
  endtask

  task automatic release_source(int i);
    tx_valid[i] = 1'b0;
  endtask

  task automatic count_busy(int i, int exp_len);
    int n;
    n = 0;
    while (busy[i] && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
    checkOutput($sformatf("busy_len[%0d]", i), n, exp_len);
  endtask

  task automatic wait_idle(int i);
    int n;
    n = 0;
    while (busy[i] && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  // Line decoder / scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        mon_act[i] = 1'b0;
      end else begin
        if (!mon_act[i] && tx_line[i] === 1'b0) begin
          logic [9:0] e;
          e = pop_exp(i);
          checkOutput($sformatf("frame_expected[%0d]", i), e[9], 1);
          mon_act[i]      = 1'b1;
          mon_cnt[i]      = 0;
          mon_exp[i]      = e[7:0];
          mon_par[i]      = e[8];
          mon_bits[i]     = {2'b11, (has_parity(i) ? e[8] : 1'b1), e[7:0], 1'b0};
          mon_shape_ok[i] = 1'b1;
          mon_ready_ok[i] = 1'b1;
          mon_dec[i]      = '0;
          mon_dec_par[i]  = 1'b0;
        end
        if (mon_act[i]) begin
          if (tx_line[i] !== mon_bits[i][mon_cnt[i] / DIV]) mon_shape_ok[i] = 1'b0;
          if (mon_cnt[i] < frame_len(i) - 1 &&
              tx_ready[i] !== (mon_cnt[i] == frame_len(i) - 2)) mon_ready_ok[i] = 1'b0;
          if (mon_cnt[i] % DIV == DIV / 2) begin
            int k;
            k = mon_cnt[i] / DIV;
            if (k >= 1 && k <= 8) mon_dec[i][k-1] = tx_line[i];
            if (k == 9) mon_dec_par[i] = tx_line[i];
          end
          if (mon_cnt[i] == frame_len(i) - 1) begin
            checkOutput($sformatf("data[%0d]", i), mon_dec[i], mon_exp[i]);
            checkOutput($sformatf("bit_timing[%0d]", i), mon_shape_ok[i], 1);
            checkOutput($sformatf("ready_window[%0d]", i), mon_ready_ok[i], 1);
            if (has_parity(i)) checkOutput($sformatf("parity[%0d]", i), mon_dec_par[i], mon_par[i]);
            mon_act[i] = 1'b0;
          end else begin
            mon_cnt[i]++;
          end
        end
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    string msg;
    int n;
    msg = "Hello World!";
    for (int i = 0; i < 4; i++) begin
      tx_data[i]  = 8'h00;
      tx_valid[i] = 1'b0;
    end

    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("reset_state", {tx_line[0], busy[0], tx_ready[0]}, 3'b101);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      checkOutput("idle_state", {tx_line[0], busy[0], tx_ready[0]}, 3'b101);
    end

    // Single byte 'H': line still high on the accepting edge, low one edge later.
    applyStimulus(0, 8'h48, 1'b0);
    release_source(0);
    checkOutput("line_at_accept", tx_line[0], 1);
    @(posedge clk);
    #1;
    checkOutput("start_bit", tx_line[0], 0);
    n = 1;
    while (busy[0] && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
    checkOutput("busy_len[0]", n, 40);
    repeat (5) @(posedge clk);
    #1;

    // Back-to-back string with valid held high.
    for (int k = 0; k < 12; k++) applyStimulus(0, msg[k], 1'b0);
    release_source(0);

    // Backpressure: 0x55 offered mid-frame, replaced by 0xAA before ready.
    repeat (10) @(posedge clk);
    #1;
    tx_data[0]  = 8'h55;
    tx_valid[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("held_off_ready", tx_ready[0], 0);
    applyStimulus(0, 8'hAA, 1'b0);
    release_source(0);
    wait_idle(0);

    // Reset during data bit 3 of 0x00, then a clean 0x41 frame.
    applyStimulus(0, 8'h00, 1'b0);
    release_source(0);
    repeat (17) @(posedge clk);
    #1;
    checkOutput("pre_reset_line", tx_line[0], 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_tx", tx_line[0], 1);
    checkOutput("abort_busy", busy[0], 0);
    rst = 1'b0;
    applyStimulus(0, 8'h41, 1'b0);
    release_source(0);
    count_busy(0, 40);

    // Parity and stop-bit variants.
    applyStimulus(1, 8'h07, 1'b1);
    release_source(1);
    count_busy(1, 44);
    applyStimulus(1, 8'h48, 1'b0);
    release_source(1);
    count_busy(1, 44);
    applyStimulus(2, 8'h07, 1'b0);
    release_source(2);
    count_busy(2, 44);
    applyStimulus(3, 8'h07, 1'b1);
    release_source(3);
    count_busy(3, 48);

    n = 0;
    while ((pending() != 0 || mon_act[0] || mon_act[1] || mon_act[2] || mon_act[3]) && n < 1000) begin
      n++;
      @(posedge clk);
      #1;
    end
    checkOutput("scoreboard_drained", pending(), 0);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
